// File: rtl/approx_add_pkg.sv
// Shared types and the approximate-sum rule used by the approx_add_pipe datapath.
// approx_sum works on wide operands so one function serves every WIDTH / APPROX_BITS pair.
package approx_add_pkg;

  typedef enum logic [1:0] {AM_EXACT, AM_LOA, AM_TRUNC, AM_COPY} approx_mode_t;

  localparam int MAX_W = 63;
  localparam logic [MAX_W:0] ONE = {{MAX_W{1'b0}}, 1'b1};

  // Returns the approximate sum of the low 'width' bits of a and b, with the low k bits approximated.
  function automatic logic [MAX_W:0] approx_sum(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input approx_mode_t     mode,
    input int               width,
    input int               k
  );
    logic [MAX_W:0] w_mask;
    logic [MAX_W:0] lo_mask;
    logic [MAX_W:0] ea;
    logic [MAX_W:0] eb;
    logic [MAX_W:0] upper;
    logic           carry;
    w_mask  = (ONE << width) - ONE;
    lo_mask = (ONE << k) - ONE;
    ea      = {1'b0, a} & w_mask;
    eb      = {1'b0, b} & w_mask;
    upper   = (ea >> k) + (eb >> k);
    // lo_mask ^ (lo_mask >> 1) isolates bit k-1, and is zero when k = 0
    carry   = |(ea & eb & (lo_mask ^ (lo_mask >> 1)));
    case (mode)
      AM_LOA:   approx_sum = ((upper + {{MAX_W{1'b0}}, carry}) << k) | ((ea | eb) & lo_mask);
      AM_TRUNC: approx_sum = upper << k;
      AM_COPY:  approx_sum = (upper << k) | (ea & lo_mask);
      default:  approx_sum = ea + eb;
    endcase
  endfunction

endpackage

// File: rtl/approx_add_pipe_if.sv
// Operand/result stream bundle for approx_add_pipe.
// Handshake: a beat moves on a rising edge where valid & ready are both 1; the producer
// holds valid and its payload stable until that edge, and ready may depend on valid.
interface approx_add_pipe_if
  import approx_add_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  approx_mode_t     mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   err;

  modport master (
    output in_valid, mode, a, b, out_ready,
    input  in_ready, out_valid, sum, err
  );

  modport slave (
    input  in_valid, mode, a, b, out_ready,
    output in_ready, out_valid, sum, err
  );
endinterface

// File: rtl/approx_add_core.sv
// Combinational exact/approximate sum and absolute error for one operand pair.
module approx_add_core
  import approx_add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  approx_mode_t     mode,
  output logic [WIDTH:0]   sum,
  output logic [WIDTH:0]   err
);
  logic [MAX_W:0] approx_full;
  logic [WIDTH:0] exact;
  logic           unused_hi;

  assign approx_full = approx_sum(MAX_W'(a), MAX_W'(b), mode, WIDTH, K);
  assign exact       = {1'b0, a} + {1'b0, b};
  assign sum         = approx_full[WIDTH:0];
  // Bits above WIDTH are always zero for in-range operands.
  assign unused_hi   = ^approx_full[MAX_W:WIDTH+1];
  assign err         = (exact >= sum) ? (exact - sum) : (sum - exact);
endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined approximate adder: core ahead of an elastic register chain, with
// saturating error statistics updated on every delivered result.
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4,
  parameter int PIPE_STAGES = 2,
  parameter int STAT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  approx_add_pipe_if.slave      bus,
  input  logic                  stat_clr,
  output logic [STAT_W-1:0]     stat_count,
  output logic [STAT_W-1:0]     stat_err_sum,
  output logic [WIDTH:0]        stat_wce,
  output logic [STAT_W-1:0]     stat_err_cnt
);
  if (WIDTH < 2 || WIDTH > MAX_W - 1 || APPROX_BITS < 0 || APPROX_BITS > WIDTH ||
      PIPE_STAGES < 1 || PIPE_STAGES > 4 || STAT_W < 1) begin : g_bad_param
    $error("approx_add_pipe: illegal parameters WIDTH=%0d APPROX_BITS=%0d PIPE_STAGES=%0d",
           WIDTH, APPROX_BITS, PIPE_STAGES);
  end

  logic [WIDTH:0] core_sum;
  logic [WIDTH:0] core_err;

  approx_add_core #(
    .WIDTH (WIDTH),
    .K     (APPROX_BITS)
  ) u_core (
    .a    (bus.a),
    .b    (bus.b),
    .mode (bus.mode),
    .sum  (core_sum),
    .err  (core_err)
  );

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    logic           vld;
    logic           adv;
    logic           in_vld;
    logic [WIDTH:0] in_sum;
    logic [WIDTH:0] in_err;
    logic [WIDTH:0] sum_r;
    logic [WIDTH:0] err_r;

    if (i == PIPE_STAGES - 1) begin : g_last
      assign adv = !vld | bus.out_ready;
    end else begin : g_mid
      assign adv = !vld | g_stage[i+1].adv;
    end

    if (i == 0) begin : g_first
      assign in_vld = bus.in_valid;
      assign in_sum = core_sum;
      assign in_err = core_err;
    end else begin : g_chain
      assign in_vld = g_stage[i-1].vld;
      assign in_sum = g_stage[i-1].sum_r;
      assign in_err = g_stage[i-1].err_r;
    end

    // A stage that does not advance keeps its contents, which is what holds the output stable.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld   <= 1'b0;
        sum_r <= '0;
        err_r <= '0;
      end else if (adv) begin
        vld   <= in_vld;
        sum_r <= in_sum;
        err_r <= in_err;
      end
    end
  end

  assign bus.in_ready  = g_stage[0].adv;
  assign bus.out_valid = g_stage[PIPE_STAGES-1].vld;
  assign bus.sum       = g_stage[PIPE_STAGES-1].sum_r;
  assign bus.err       = g_stage[PIPE_STAGES-1].err_r;

  localparam int SUM_W = ((STAT_W > WIDTH + 1) ? STAT_W : WIDTH + 1) + 1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic              out_hs;
  logic [SUM_W-1:0]  err_sum_ext;
  logic [STAT_W-1:0] err_sum_sat;

  assign out_hs      = bus.out_valid & bus.out_ready;
  assign err_sum_ext = SUM_W'(stat_err_sum) + SUM_W'(bus.err);
  assign err_sum_sat = (err_sum_ext > SUM_W'(STAT_MAX)) ? STAT_MAX : err_sum_ext[STAT_W-1:0];

  // Clear has priority over a coincident handshake; that result goes uncounted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_count   <= '0;
      stat_err_sum <= '0;
      stat_wce     <= '0;
      stat_err_cnt <= '0;
    end else if (stat_clr) begin
      stat_count   <= '0;
      stat_err_sum <= '0;
      stat_wce     <= '0;
      stat_err_cnt <= '0;
    end else if (out_hs) begin
      if (stat_count != STAT_MAX) stat_count <= stat_count + STAT_W'(1);
      stat_err_sum <= err_sum_sat;
      if (bus.err != '0 && stat_err_cnt != STAT_MAX) stat_err_cnt <= stat_err_cnt + STAT_W'(1);
      if (bus.err > stat_wce) stat_wce <= bus.err;
    end
  end
endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed and randomized checks of approx_add_pipe against an arithmetic reference model.
module tb_approx_add_pipe;
  import approx_add_pkg::*;

  localparam int W = 8;
  localparam longint LIM32 = 64'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_sum(input int a, input int b, input int m, input int k);
    int p, al, bl, au, bu, c;
    p  = 1 << k;
    al = a % p;  bl = b % p;
    au = a / p;  bu = b / p;
    c  = (k > 0 && al >= p / 2 && bl >= p / 2) ? 1 : 0;
    case (m)
      1:       return (au + bu + c) * p + (al | bl);
      2:       return (au + bu) * p;
      3:       return (au + bu) * p + al;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [2*W+1:0] expect_pair(input int a, input int b, input int m, input int k);
    int s, e;
    s = model_sum(a, b, m, k);
    e = (a + b >= s) ? (a + b - s) : (s - (a + b));
    return {(W+1)'(s), (W+1)'(e)};
  endfunction

  // ---------------- DUTs ----------------
  approx_add_pipe_if #(.WIDTH(W)) ifm ();
  approx_add_pipe_if #(.WIDTH(W)) ifs ();
  approx_add_pipe_if #(.WIDTH(W)) ifz ();

  logic          clr_m = 1'b0, clr_s = 1'b0, clr_z = 1'b0;
  logic [31:0]   cnt_m, esum_m, ecnt_m;
  logic [W:0]    wce_m;
  logic [3:0]    cnt_s, esum_s, ecnt_s;
  logic [W:0]    wce_s;
  logic [31:0]   cnt_z, esum_z, ecnt_z;
  logic [W:0]    wce_z;

  approx_add_pipe #(.WIDTH(W), .APPROX_BITS(4), .PIPE_STAGES(2), .STAT_W(32)) u_dut_m (
    .clk(clk), .rst(rst), .bus(ifm.slave), .stat_clr(clr_m),
    .stat_count(cnt_m), .stat_err_sum(esum_m), .stat_wce(wce_m), .stat_err_cnt(ecnt_m));

  approx_add_pipe #(.WIDTH(W), .APPROX_BITS(4), .PIPE_STAGES(2), .STAT_W(4)) u_dut_s (
    .clk(clk), .rst(rst), .bus(ifs.slave), .stat_clr(clr_s),
    .stat_count(cnt_s), .stat_err_sum(esum_s), .stat_wce(wce_s), .stat_err_cnt(ecnt_s));

  approx_add_pipe #(.WIDTH(W), .APPROX_BITS(0), .PIPE_STAGES(3), .STAT_W(32)) u_dut_z (
    .clk(clk), .rst(rst), .bus(ifz.slave), .stat_clr(clr_z),
    .stat_count(cnt_z), .stat_err_sum(esum_z), .stat_wce(wce_z), .stat_err_cnt(ecnt_z));

  // ---------------- scoreboard ----------------
  logic [2*W+1:0] exp_q[$];
  logic [2*W+1:0] exp_zq[$];
  longint m_count = 0, m_esum = 0, m_ecnt = 0, m_wce = 0;
  logic           held = 1'b0;
  logic [2*W+1:0] held_v;
  logic [2*W+1:0] mon_e;
  logic [2*W+1:0] mon_z;

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 64'(ifm.out_valid), 64'd1);
        check("hold_data", 64'({ifm.sum, ifm.err}), 64'(held_v));
      end
      if (ifm.out_valid && ifm.out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_with_empty_queue", 64'(ifm.out_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sum", 64'(ifm.sum), 64'(mon_e[2*W+1:W+1]));
          check("err", 64'(ifm.err), 64'(mon_e[W:0]));
          if (!clr_m) begin
            m_count = (m_count < LIM32) ? m_count + 1 : LIM32;
            m_esum  = (m_esum + mon_e[W:0] > LIM32) ? LIM32 : m_esum + mon_e[W:0];
            if (mon_e[W:0] != 0) m_ecnt = (m_ecnt < LIM32) ? m_ecnt + 1 : LIM32;
            if (mon_e[W:0] > m_wce) m_wce = mon_e[W:0];
          end
        end
      end
      if (clr_m) begin
        m_count = 0; m_esum = 0; m_ecnt = 0; m_wce = 0;
      end
      held   = ifm.out_valid && !ifm.out_ready;
      held_v = {ifm.sum, ifm.err};
    end
  end

  always @(negedge clk) begin
    if (!rst && ifz.out_valid && ifz.out_ready) begin
      if (exp_zq.size() == 0) begin
        check("z_out_with_empty_queue", 64'(ifz.out_valid), 64'd0);
      end else begin
        mon_z = exp_zq.pop_front();
        check("z_sum", 64'(ifz.sum), 64'(mon_z[2*W+1:W+1]));
        check("z_err", 64'(ifz.err), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_m(input int a, input int b, input int m, input bit rnd_ready);
    bit done;
    int t;
    done = 1'b0;
    t    = 0;
    ifm.a        = a[W-1:0];
    ifm.b        = b[W-1:0];
    ifm.mode     = approx_mode_t'(m[1:0]);
    ifm.in_valid = 1'b1;
    while (!done && t < 200) begin
      if (rnd_ready) ifm.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      done = ifm.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (done) exp_q.push_back(expect_pair(a, b, m, 4));
    else check("push_timeout", 64'(done), 64'd1);
    ifm.in_valid = 1'b0;
  endtask

  task automatic drain_m();
    int t;
    t = 0;
    ifm.out_ready = 1'b1;
    while (exp_q.size() > 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_count"},   64'(cnt_m),  64'(m_count));
    check({tag, "_err_sum"}, 64'(esum_m), 64'(m_esum));
    check({tag, "_wce"},     64'(wce_m),  64'(m_wce));
    check({tag, "_err_cnt"}, 64'(ecnt_m), 64'(m_ecnt));
  endtask

  // ---------------- directed / random sequence ----------------
  initial begin
    int a, b, m, acc, t;
    logic [2*W+1:0] pe;
    rst = 1'b1;
    ifm.in_valid = 1'b0; ifm.a = '0; ifm.b = '0; ifm.mode = AM_EXACT; ifm.out_ready = 1'b1;
    ifs.in_valid = 1'b0; ifs.a = '0; ifs.b = '0; ifs.mode = AM_EXACT; ifs.out_ready = 1'b1;
    ifz.in_valid = 1'b0; ifz.a = '0; ifz.b = '0; ifz.mode = AM_EXACT; ifz.out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(ifm.out_valid), 64'd0);
    check("rst_in_ready",  64'(ifm.in_ready),  64'd1);
    check("rst_sum",       64'(ifm.sum),       64'd0);
    check("rst_err",       64'(ifm.err),       64'd0);
    check_stats("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // exact add and latency
    push_m(200, 100, 0, 1'b0);
    @(negedge clk);
    check("lat_not_yet", 64'(ifm.out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid", 64'(ifm.out_valid), 64'd1);
    check("t1_sum",    64'(ifm.sum),       64'd300);
    check("t1_err",    64'(ifm.err),       64'd0);
    @(posedge clk);
    #1;

    // the three approximate modes
    push_m(8'h0F, 8'h0F, 1, 1'b0);
    push_m(8'h37, 8'h29, 2, 1'b0);
    push_m(8'h37, 8'h29, 3, 1'b0);
    drain_m();
    check("t3_count",   64'(cnt_m),  64'd4);
    check("t3_err_sum", 64'(esum_m), 64'd26);
    check("t3_wce",     64'(wce_m),  64'd16);
    check("t3_err_cnt", 64'(ecnt_m), 64'd3);
    clr_m = 1'b1;
    @(posedge clk);
    #1;
    clr_m = 1'b0;
    check("clr_count",   64'(cnt_m),  64'd0);
    check("clr_err_sum", 64'(esum_m), 64'd0);
    check("clr_wce",     64'(wce_m),  64'd0);
    check("clr_err_cnt", 64'(ecnt_m), 64'd0);

    // backpressure: two beats fill the pipe, third must stall
    ifm.out_ready = 1'b0;
    push_m($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), 1'b0);
    push_m($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), 1'b0);
    ifm.in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready", 64'(ifm.in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    ifm.in_valid  = 1'b0;
    ifm.out_ready = 1'b1;
    push_m($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), 1'b0);
    push_m($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), 1'b0);
    drain_m();
    check_stats("bp");

    // random traffic with random backpressure, mode changes and occasional clears
    for (int i = 0; i < 150; i++) begin
      clr_m = ($urandom_range(0, 19) == 0);
      push_m($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), 1'b1);
      clr_m = 1'b0;
    end
    drain_m();
    check_stats("rand");

    // clear coincident with a handshake of err = 16
    push_m(8'h11, 8'h0F, 1, 1'b0);
    drain_m();
    ifm.out_ready = 1'b0;
    push_m(8'h37, 8'h29, 2, 1'b0);
    @(posedge clk);
    #1;
    clr_m = 1'b1;
    ifm.out_ready = 1'b1;
    @(posedge clk);
    #1;
    clr_m = 1'b0;
    check("clrhs_delivered", 64'(exp_q.size()), 64'd0);
    check("clrhs_count",     64'(cnt_m),        64'd0);
    check("clrhs_err_sum",   64'(esum_m),       64'd0);
    check("clrhs_wce",       64'(wce_m),        64'd0);

    // reset with two beats in flight
    push_m(8'hFF, 8'h01, 3, 1'b0);
    push_m(8'h80, 8'h80, 1, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(ifm.out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(ifm.in_ready),  64'd1);
    check("mid_rst_count",     64'(cnt_m),         64'd0);
    check("mid_rst_err_sum",   64'(esum_m),        64'd0);
    exp_q.delete();
    m_count = 0; m_esum = 0; m_ecnt = 0; m_wce = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_m(8'h9C, 8'h47, 1, 1'b0);
    drain_m();
    check_stats("post_rst");

    // saturating counters on the 4-bit statistics instance
    ifs.mode = AM_TRUNC; ifs.a = 8'h37; ifs.b = 8'h29; ifs.in_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    ifs.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    pe = expect_pair(8'h37, 8'h29, 2, 4);
    check("sat_count",   64'(cnt_s),  64'(20 > 15 ? 15 : 20));
    check("sat_err_sum", 64'(esum_s), 64'((20 * pe[W:0] > 15) ? 15 : 20 * pe[W:0]));
    check("sat_err_cnt", 64'(ecnt_s), 64'(20 > 15 ? 15 : 20));
    check("sat_wce",     64'(wce_s),  64'(pe[W:0]));

    // APPROX_BITS = 0 is exact in every mode
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      m = $urandom_range(0, 3);
      ifz.a = a[W-1:0]; ifz.b = b[W-1:0]; ifz.mode = approx_mode_t'(m[1:0]); ifz.in_valid = 1'b1;
      @(negedge clk);
      acc = ifz.in_ready;
      @(posedge clk);
      if (acc != 0) exp_zq.push_back(expect_pair(a, b, m, 0));
      #1;
    end
    ifz.in_valid = 1'b0;
    t = 0;
    while (exp_zq.size() > 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("z_drain_empty", 64'(exp_zq.size()), 64'd0);
    check("z_count",       64'(cnt_z),          64'd12);
    check("z_err_cnt",     64'(ecnt_z),         64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed time %0t expected completion", $time);
    $fatal(1, "global timeout");
  end
endmodule
